// File: rtl/dpll_pkg.sv
// Shared definitions for the DPLL reference stimulus generator: FSM states and
// the frequency-control code values presented to the DPLL under test.
package dpll_pkg;

    localparam int FREQ_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [FREQ_W-1:0] CODE_00 = 2'b00;
    localparam logic [FREQ_W-1:0] CODE_01 = 2'b01;
    localparam logic [FREQ_W-1:0] CODE_10 = 2'b10;
    localparam logic [FREQ_W-1:0] CODE_11 = 2'b11;

endpackage

// File: rtl/dpll_half_period_div.sv
// Half-period down-counter: reloads with H-1 where H = (div_base+1) << code and
// flags the last cycle of each half period so the top can toggle the reference.
module dpll_half_period_div
    import dpll_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              run,
    input  logic [DIV_W-1:0]  div_base,
    input  logic [FREQ_W-1:0] code,
    output logic              toggle
);

    localparam int HW = DIV_W + 3;

    logic [HW-1:0] cnt;
    logic [HW-1:0] reload;

    // H-1 built as {div_base, code ones}, which never exceeds HW bits.
    always_comb begin
        reload = (HW'(div_base) << code) | ((HW'(1) << code) - HW'(1));
    end

    assign toggle = run && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= reload;
        end else if (run) begin
            cnt <= toggle ? reload : cnt - HW'(1);
        end
    end

endmodule

// File: rtl/dpll_stim_gen.sv
// Reference clock stimulus generator stepping freq_ctl through 00..11.
// Optional macro DPLL_STIM_LOOP_EN: wrap 11->00 continuously until start_i stops it.
module dpll_stim_gen
    import dpll_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int DWELL_W = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               start_i,
    input  logic [DIV_W-1:0]   div_base_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic               ref_o,
    output logic [FREQ_W-1:0]  freq_ctl_o,
    output logic               busy_o,
    output logic               step_o,
    output logic               done_o,
    output logic [1:0]         state_o
);

    // Handshake: start_i is a single-cycle request sampled only in IDLE
    // (and, in the loop build, in RUN as a stop request); outputs are registered.

    state_t              state, next_state;
    logic                ref_q, ref_n;
    logic [FREQ_W-1:0]   code_q, code_n;
    logic [DWELL_W-1:0]  per_cnt, per_n;
    logic [DIV_W-1:0]    base_q, base_n;
    logic [DWELL_W-1:0]  dwell_q, dwell_n;
    logic                step_n, done_n, busy_q, busy_n;
    logic                load, run, toggle, stop_now;

`ifdef DPLL_STIM_LOOP_EN
    logic stop_q, stop_n;
    assign stop_now = stop_q;
`else
    assign stop_now = 1'b0;
`endif

    dpll_half_period_div #(
        .DIV_W (DIV_W)
    ) u_div (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (load),
        .run      (run),
        .div_base (base_n),
        .code     (code_n),
        .toggle   (toggle)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ref_n      = ref_q;
        code_n     = code_q;
        per_n      = per_cnt;
        base_n     = base_q;
        dwell_n    = dwell_q;
        step_n     = 1'b0;
        done_n     = 1'b0;
        load       = 1'b0;
        run        = 1'b0;
`ifdef DPLL_STIM_LOOP_EN
        stop_n     = stop_q;
`endif
        case (state)
            IDLE: begin
                if (start_i) begin
                    next_state = RUN;
                    base_n     = div_base_i;
                    dwell_n    = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
                    code_n     = CODE_00;
                    ref_n      = 1'b0;
                    per_n      = '0;
                    load       = 1'b1;
`ifdef DPLL_STIM_LOOP_EN
                    stop_n     = 1'b0;
`endif
                end
            end
            RUN: begin
                run = 1'b1;
`ifdef DPLL_STIM_LOOP_EN
                if (start_i) begin
                    stop_n = 1'b1;
                end
`endif
                if (toggle) begin
                    ref_n = ~ref_q;
                    // A high-to-low toggle closes one reference period.
                    if (ref_q) begin
                        if (stop_now) begin
                            next_state = DONE;
                            done_n     = 1'b1;
                        end else if (per_cnt == dwell_q - DWELL_W'(1)) begin
                            per_n = '0;
                            if (code_q == CODE_11) begin
`ifdef DPLL_STIM_LOOP_EN
                                code_n = CODE_00;
                                step_n = 1'b1;
                                done_n = 1'b1;
`else
                                next_state = DONE;
                                done_n     = 1'b1;
`endif
                            end else begin
                                code_n = code_q + 2'd1;
                                step_n = 1'b1;
                            end
                        end else begin
                            per_n = per_cnt + DWELL_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
`ifdef DPLL_STIM_LOOP_EN
                stop_n     = 1'b0;
`endif
            end
            default: next_state = IDLE;
        endcase
        busy_n = (next_state != IDLE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ref_q   <= 1'b0;
            code_q  <= CODE_00;
            per_cnt <= '0;
            base_q  <= '0;
            dwell_q <= '0;
            step_o  <= 1'b0;
            done_o  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DPLL_STIM_LOOP_EN
            stop_q  <= 1'b0;
`endif
        end else begin
            ref_q   <= ref_n;
            code_q  <= code_n;
            per_cnt <= per_n;
            base_q  <= base_n;
            dwell_q <= dwell_n;
            step_o  <= step_n;
            done_o  <= done_n;
            busy_q  <= busy_n;
`ifdef DPLL_STIM_LOOP_EN
            stop_q  <= stop_n;
`endif
        end
    end

    assign ref_o      = ref_q;
    assign freq_ctl_o = code_q;
    assign busy_o     = busy_q;
    assign state_o    = state;

endmodule
